// File: rtl/kr580_timer.sv
// Port-mapped 16-bit interval timer for the kr580 core: prescaled down-counter
// with reload, one-shot mode, snapshot register and a level interrupt request.
module kr580_timer #(
  parameter logic [7:0]  BASE     = 8'h40,
  parameter int unsigned PRESCALE = 4
) (
  input  logic       pin_clk,
  input  logic       pin_rst,
  input  logic [7:0] pin_pa,
  input  logic [7:0] pin_po,
  input  logic       pin_pw,
  output logic [7:0] pin_pi,
  output logic       pin_intr
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] reload_q, reload_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] snap_q, snap_d;
  logic [15:0] pre_q, pre_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  logic        oneshot_q, oneshot_d;
  logic        pending_q, pending_d;

  logic [7:0]  off;
  logic        hit;
  logic        wr_lo, wr_hi, wr_ctrl, wr_stat;
  logic        run, tick, term;

  assign off     = pin_pa - BASE;
  assign hit     = (off[7:2] == 6'd0);
  assign wr_lo   = pin_pw && hit && (off[1:0] == 2'd0);
  assign wr_hi   = pin_pw && hit && (off[1:0] == 2'd1);
  assign wr_ctrl = pin_pw && hit && (off[1:0] == 2'd2);
  assign wr_stat = pin_pw && hit && (off[1:0] == 2'd3);

  // A ctrl write that disables the timer suppresses the tick on the same edge.
  assign run  = en_q && !(wr_ctrl && !pin_po[0]);
  assign tick = run && (pre_q == PRE_LAST);
  assign term = tick && !wr_hi && (cnt_q == 16'd1);

  always_comb begin
    reload_d  = reload_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    en_d      = en_q;
    irq_en_d  = irq_en_q;
    oneshot_d = oneshot_q;
    pending_d = pending_q;
    pre_d     = (run && !tick) ? pre_q + 16'd1 : 16'd0;

    if (wr_lo) reload_d[7:0] = pin_po;

    if (wr_hi) begin
      reload_d[15:8] = pin_po;
      cnt_d          = {pin_po, reload_q[7:0]};
      pre_d          = 16'd0;
    end else if (tick) begin
      if (cnt_q == 16'd1) cnt_d = oneshot_q ? 16'd0 : reload_q;
      else                cnt_d = cnt_q - 16'd1;
    end

    if (wr_ctrl) begin
      en_d      = pin_po[0];
      irq_en_d  = pin_po[1];
      oneshot_d = pin_po[2];
      if (pin_po[7]) snap_d = cnt_q;
    end
    if (term && oneshot_q) en_d = 1'b0;

    // Set beats clear when both land on the same edge.
    if (wr_stat && pin_po[0]) pending_d = 1'b0;
    if (term)                 pending_d = 1'b1;
  end

  always_ff @(posedge pin_clk) begin
    if (pin_rst) begin
      reload_q  <= 16'd0;
      cnt_q     <= 16'd0;
      snap_q    <= 16'd0;
      pre_q     <= 16'd0;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      oneshot_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      reload_q  <= reload_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      pre_q     <= pre_d;
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      oneshot_q <= oneshot_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    pin_pi = 8'h00;
    if (hit) begin
      case (off[1:0])
        2'd0:    pin_pi = snap_q[7:0];
        2'd1:    pin_pi = snap_q[15:8];
        2'd2:    pin_pi = {5'b0, oneshot_q, irq_en_q, en_q};
        default: pin_pi = {7'b0, pending_q};
      endcase
    end
  end

  assign pin_intr = pending_q & irq_en_q;

endmodule
